// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues word-aligned requests at pc,
// holds each returned instruction until decode accepts it, and handles flush and misaligned-PC faults.
module instr_fetch #(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [xlen-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [xlen-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [31:0]     instr,
    output logic [xlen-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } state_t;

    state_t          state_q;
    logic [31:0]     instr_q;
    logic [xlen-1:0] instr_pc_q;
    logic            instr_valid_q;
    logic            fault_q;
    logic [31:0]     fetch_count_q;
    logic [31:0]     fetch_count_d;
    logic            deliver;

    // The request is valid only in the cycle it is offered; a flush withdraws it immediately.
    assign imem_req_valid = !rst && (state_q == REQ) && (pc[1:0] == 2'b00) && !flush;
    assign imem_req_addr  = pc;
    assign pc_en          = !rst && ((flush && (state_q != IDLE)) || (imem_req_valid && imem_req_ready));

    // A flush in HOLD cancels the delivery even if decode is ready the same cycle.
    assign deliver = (state_q == HOLD) && instr_ready && !flush;

    // NOTE: always_comb assigns every output unconditionally, so no latch can be inferred.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(deliver);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (!flush) begin
                        if (pc[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else if (imem_req_ready) begin
                            instr_pc_q <= pc;
                            state_q    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        // A response arriving with the flush retires the request; otherwise it is still owed.
                        state_q <= imem_resp_valid ? REQ : DRAIN;
                    end else if (imem_resp_valid) begin
                        instr_q       <= imem_resp_data;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= REQ;
                    end
                end
                DRAIN: begin
                    if (!flush && imem_resp_valid) begin
                        state_q <= REQ;
                    end
                end
                FAULT: begin
                    if (flush) begin
                        fault_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic, compared every cycle
// against a transaction-level model (request owed / response owed / instruction held / faulted).
module tb_instr_fetch;

    localparam int xlen = 64;

    logic            clk;
    logic            rst;
    logic [xlen-1:0] pc;
    logic            pc_en;
    logic            flush;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [xlen-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic [31:0]     instr;
    logic [xlen-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            fault;
    logic [31:0]     fetch_count;

    instr_fetch #(.xlen(xlen)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_en           (pc_en),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [xlen-1:0] pc;
        logic            flush;
        logic            ready;
        logic            rv;
        logic [31:0]     rd;
        logic            iready;
    } stim_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the fetch unit owes, not how it encodes it.
    bit              m_started;   // first post-reset cycle has passed
    bit              m_pending;   // accepted request awaiting its response
    bit              m_discard;   // a response is owed but must be thrown away
    bit              m_have;      // instruction held for decode
    bit              m_fault;
    logic [31:0]     m_instr;
    logic [xlen-1:0] m_ipc;
    logic [31:0]     m_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_pending = 0;
        m_discard = 0;
        m_have    = 0;
        m_fault   = 0;
        m_instr   = '0;
        m_ipc     = '0;
        m_count   = '0;
    endtask

    function automatic stim_t quiet(input logic [xlen-1:0] p);
        stim_t s;
        s.rst = 0; s.pc = p; s.flush = 0; s.ready = 0; s.rv = 0; s.rd = '0; s.iready = 0;
        return s;
    endfunction

    // One clock: check registered outputs, apply inputs, check combinational outputs, advance model.
    task automatic step(input stim_t s);
        bit in_req;
        bit exp_rv;
        bit exp_pe;
        @(negedge clk);
        check("instr_valid", 64'(instr_valid), 64'(m_have));
        check("instr",       64'(instr),       64'(m_instr));
        check("instr_pc",    64'(instr_pc),    64'(m_ipc));
        check("fault",       64'(fault),       64'(m_fault));
        check("fetch_count", 64'(fetch_count), 64'(m_count));

        rst             = s.rst;
        pc              = s.pc;
        flush           = s.flush;
        imem_req_ready  = s.ready;
        imem_resp_valid = s.rv;
        imem_resp_data  = s.rd;
        instr_ready     = s.iready;
        #1;

        in_req = m_started && !m_pending && !m_discard && !m_have && !m_fault;
        exp_rv = !s.rst && in_req && (s.pc % 4 == 0) && !s.flush;
        exp_pe = !s.rst && ((s.flush && m_started) || (exp_rv && s.ready));
        check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        check("pc_en",     64'(pc_en),          64'(exp_pe));
        if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(s.pc));

        if (s.rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_fault) begin
            if (s.flush) m_fault = 0;
        end else if (m_have) begin
            if (s.flush) m_have = 0;
            else if (s.iready) begin
                m_have  = 0;
                m_count = m_count + 1;
            end
        end else if (m_pending) begin
            if (s.flush) begin
                m_pending = 0;
                m_discard = !s.rv;
            end else if (s.rv) begin
                m_pending = 0;
                m_have    = 1;
                m_instr   = s.rd;
            end
        end else if (m_discard) begin
            if (s.rv && !s.flush) m_discard = 0;
        end else if (!s.flush) begin
            if (s.pc % 4 != 0) m_fault = 1;
            else if (s.ready) begin
                m_pending = 1;
                m_ipc     = s.pc;
            end
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    stim_t s;

    initial begin
        rst = 1; pc = '0; flush = 0; imem_req_ready = 0;
        imem_resp_valid = 0; imem_resp_data = '0; instr_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Basic fetch at pc 0 with response one cycle after accept.
        s = quiet(64'h0);           step(s);   // IDLE -> REQ
        s.ready = 1;                step(s);   // accept, pc_en pulse
        s = quiet(64'h4); s.rv = 1; s.rd = 32'h0050_0093; step(s);
        post_edge();
        check("d031_instr",    64'(instr),       64'h0050_0093);
        check("d031_instr_pc", 64'(instr_pc),    64'h0);
        check("d031_valid",    64'(instr_valid), 64'h1);
        s = quiet(64'h4); s.iready = 1; step(s);
        post_edge();
        check("d031_count", 64'(fetch_count), 64'h1);

        // Memory not ready for three cycles at pc 8.
        s = quiet(64'h8);
        repeat (3) step(s);
        s.ready = 1; step(s);
        s = quiet(64'hC); s.rv = 1; s.rd = 32'h1234_5678; step(s);

        // Decode stalls four cycles while the instruction is held.
        s = quiet(64'hC);
        repeat (4) step(s);
        post_edge();
        check("d033_instr_pc", 64'(instr_pc),    64'h8);
        check("d033_count",    64'(fetch_count), 64'h1);
        s.iready = 1; step(s);

        // Flush while waiting; late response is drained, fetch resumes at the target.
        s = quiet(64'h10); s.ready = 1; step(s);
        s = quiet(64'h40); s.flush = 1; step(s);
        s = quiet(64'h40); step(s);
        s.rv = 1; s.rd = 32'hDEAD_BEEF; step(s);
        post_edge();
        check("d034_no_valid", 64'(instr_valid), 64'h0);
        s = quiet(64'h40); s.ready = 1; step(s);
        check("d034_addr", 64'(imem_req_addr), 64'h40);
        s = quiet(64'h44); s.rv = 1; s.rd = 32'h0000_0013; step(s);
        s = quiet(64'h44); s.iready = 1; step(s);

        // Misaligned pc faults; flush to 0x10 clears it and fetch restarts there.
        s = quiet(64'h6);
        repeat (4) step(s);
        post_edge();
        check("d035_fault", 64'(fault), 64'h1);
        s = quiet(64'h10); s.flush = 1; step(s);
        s = quiet(64'h10); s.ready = 1; step(s);
        check("d035_addr", 64'(imem_req_addr), 64'h10);
        check("d035_fault_clr", 64'(fault), 64'h0);

        // Counter wrap: preload to all-ones while an instruction is held, then deliver.
        s = quiet(64'h14); s.rv = 1; s.rd = 32'hCAFE_0001; step(s);
        s = quiet(64'h14); step(s);
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        post_edge();
        release dut.fetch_count_q;
        s.iready = 1; step(s);
        post_edge();
        check("d036_wrap", 64'(fetch_count), 64'h0);

        // Reset abandons an outstanding request; the late response is ignored.
        s = quiet(64'h20); s.ready = 1; step(s);
        s = quiet(64'h20); s.rst = 1; step(s);
        s = quiet(64'h20); s.rv = 1; s.rd = 32'hBAD0_BAD0; step(s);
        s = quiet(64'h20); step(s);
        post_edge();
        check("d030_no_valid", 64'(instr_valid), 64'h0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            s.rst    = ($urandom_range(0, 199) == 0);
            s.pc     = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 15) != 0) s.pc[1:0] = 2'b00;
            s.flush  = ($urandom_range(0, 11) == 0);
            s.ready  = 1'($urandom);
            s.rv     = 1'($urandom);
            s.rd     = $urandom;
            s.iready = 1'($urandom);
            step(s);
        end

        s = quiet(64'h0); step(s);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter xlen SHALL be: xlen, default 64, address/PC width in bits.
REQ-002 Port clk SHALL be: clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-004 Port pc SHALL be: pc  input  xlen  current PC from program counter.
REQ-005 Port pc_en SHALL be: pc_en  output  1  enable for PC register update this edge.
REQ-006 Port flush SHALL be: flush  input  1  branch taken; discard current/in-flight fetch.
REQ-007 Ports imem_req_valid/imem_req_ready/imem_req_addr SHALL be: output 1 / input 1 / output xlen, instruction-memory request handshake.
REQ-008 Ports imem_resp_valid/imem_resp_data SHALL be: input 1 / input 32, instruction-memory response.
REQ-009 Ports instr/instr_pc/instr_valid/instr_ready SHALL be: output 32 / output xlen / output 1 / input 1, decode-side handshake.
REQ-010 Port fault SHALL be: fault  output  1  misaligned-fetch fault, sticky.
REQ-011 Port fetch_count SHALL be: fetch_count  output  32  count of instructions delivered to decode.

Function
REQ-012 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN, FAULT; at most one memory request outstanding; responses in order.
REQ-013 IDLE SHALL transition to REQ on the next edge unconditionally.
REQ-014 In REQ with pc[1:0]==0 and flush==0: imem_req_valid=1, imem_req_addr=pc.
REQ-015 In REQ with pc[1:0]!=0 and flush==0: no request, next state FAULT.
REQ-016 REQ handshake (imem_req_valid & imem_req_ready) SHALL assert pc_en that cycle, capture pc into instr_pc, next state WAIT.
REQ-017 imem_req_valid SHALL be combinationally masked by flush; valid need not remain stable without ready.
REQ-018 In REQ without handshake, state SHALL hold and pc_en SHALL be 0 (except REQ-023).
REQ-019 In WAIT, imem_resp_valid SHALL latch imem_resp_data into instr, set instr_valid, next state HOLD; minimum req-accept-to-instr_valid latency 2 cycles.
REQ-020 In HOLD, instr/instr_pc/instr_valid SHALL stay stable until instr_ready; on instr_valid & instr_ready: fetch_count+1, instr_valid cleared, next state REQ.
REQ-021 fetch_count SHALL wrap 0xFFFFFFFF -> 0.
REQ-022 imem_resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-023 flush SHALL assert pc_en the same cycle (PC loads branch target), in every state except IDLE.
REQ-024 flush in REQ: no request issued, stay REQ.
REQ-025 flush in WAIT without resp: next DRAIN; with resp same cycle: response discarded, next REQ.
REQ-026 flush in HOLD: instr_valid cleared next edge, no fetch_count increment even if instr_ready, next REQ.
REQ-027 DRAIN SHALL discard the next response, then go REQ; flush in DRAIN stays DRAIN.
REQ-028 FAULT SHALL hold fault=1, issue no requests, pc_en=0; flush clears fault and goes REQ.

Reset
REQ-029 rst SHALL take priority over all inputs: state IDLE, instr_valid=0, instr=0, instr_pc=0, fault=0, fetch_count=0, imem_req_valid=0, pc_en=0.
REQ-030 rst asserted mid-WAIT SHALL abandon the outstanding request; a late response SHALL be ignored per REQ-022.

Verification
REQ-031 Reset release, pc=0x0, ready=1, resp 1 cycle later data 0x00500093 -> instr=0x00500093, instr_pc=0x0, instr_valid 2 cycles after accept, pc_en one-cycle pulse.
REQ-032 imem_req_ready low 3 cycles at pc=0x8 -> imem_req_valid held, pc_en 0 for 3 cycles, single pulse on accept.
REQ-033 instr_ready low 4 cycles in HOLD -> instr/instr_pc stable, no new request, fetch_count unchanged until handshake.
REQ-034 flush during WAIT, response 2 cycles later -> DRAIN, response discarded, instr_valid never set, next request at new pc.
REQ-035 pc=0x6 -> no request, fault=1 sticky; flush with pc=0x10 -> fault=0, request addr 0x10.
REQ-036 fetch_count preloaded to 0xFFFFFFFF via 2^32-1 deliveries (or forced) -> next delivery reads 0.
